// File: rtl/store_byte_merge.sv
// Read-modify-write engine for sub-quadword stores: fetches the containing quadword,
// inserts the store bytes at their lane and writes the merged quadword back.

`ifndef OP_SZ_BYTE
`define OP_SZ_BYTE 2'd0
`endif
`ifndef OP_SZ_WORD
`define OP_SZ_WORD 2'd1
`endif
`ifndef OP_SZ_LWRD
`define OP_SZ_LWRD 2'd2
`endif
`ifndef OP_SZ_QWRD
`define OP_SZ_QWRD 2'd3
`endif

module store_byte_merge #(
   parameter int AW           = 64,
   parameter bit SKIP_QW_READ = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [63:0]   req_data,
   input  logic [1:0]    req_size,
   output logic          done,
   output logic          misalign_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd_req,
   input  logic          mem_rd_valid,
   input  logic [63:0]   mem_rd_data,
   output logic          mem_wr_req,
   output logic [63:0]   mem_wr_data,
   output logic [7:0]    mem_wr_be,
   input  logic          mem_wr_ack,
   output logic [1:0]    dbg_state
);

   // Handshakes: a request transfers on a clock edge where req_valid & req_ready are both
   // high. mem_rd_req stays high until an edge with mem_rd_valid; mem_wr_req stays high
   // until an edge with mem_wr_ack. Address and write data do not change while held.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_done;
   logic          r_misalign;
   logic [AW-1:0] r_addr;
   logic [63:0]   r_wr_data;
   logic [7:0]    r_be;
   logic [63:0]   r_ins;

   logic          w_accept;
   logic [2:0]    w_lane;
   logic          w_misalign;
   logic          w_skip;
   logic [7:0]    w_size_mask;
   logic [7:0]    w_be;
   logic [63:0]   w_ins;
   logic [63:0]   w_bem;
   logic [63:0]   w_merged;

   assign w_accept = req_valid && req_ready;
   assign w_lane   = req_addr[2:0];
   assign w_skip   = SKIP_QW_READ && (req_size == `OP_SZ_QWRD);

   always_comb begin
      w_misalign  = 1'b0;
      w_size_mask = 8'h01;
      case (req_size)
         `OP_SZ_BYTE: begin
            w_size_mask = 8'h01;
            w_misalign  = 1'b0;
         end
         `OP_SZ_WORD: begin
            w_size_mask = 8'h03;
            w_misalign  = w_lane[0];
         end
         `OP_SZ_LWRD: begin
            w_size_mask = 8'h0F;
            w_misalign  = |w_lane[1:0];
         end
         default: begin
            w_size_mask = 8'hFF;
            w_misalign  = |w_lane;
         end
      endcase
   end

   assign w_be  = w_size_mask << w_lane;
   assign w_ins = req_data << {w_lane, 3'b000};

   // The merge uses the lane mask captured at accept, expanded from bytes to bits.
   always_comb begin
      w_bem = '0;
      for (int i = 0; i < 8; i++) begin
         w_bem[i*8 +: 8] = {8{r_be[i]}};
      end
   end

   assign w_merged = (mem_rd_data & ~w_bem) | (r_ins & w_bem);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && !w_misalign) begin
               w_state_nxt = w_skip ? ST_WR : ST_RD;
            end
         end
         ST_RD: begin
            if (mem_rd_valid) begin
               w_state_nxt = ST_WR;
            end
         end
         ST_WR: begin
            if (mem_wr_ack) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_done     <= 1'b0;
         r_misalign <= 1'b0;
         r_addr     <= '0;
         r_wr_data  <= '0;
         r_be       <= '0;
         r_ins      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_done     <= (r_state == ST_WR) && mem_wr_ack;
         r_misalign <= w_accept && w_misalign;
         if (w_accept && !w_misalign) begin
            r_addr <= {req_addr[AW-1:3], 3'b000};
            r_be   <= w_be;
            r_ins  <= w_ins;
            if (w_skip) begin
               r_wr_data <= req_data;
            end
         end else if ((r_state == ST_RD) && mem_rd_valid) begin
            r_wr_data <= w_merged;
         end
      end
   end

   assign req_ready    = (r_state == ST_IDLE);
   assign mem_rd_req   = (r_state == ST_RD);
   assign mem_wr_req   = (r_state == ST_WR);
   assign done         = r_done;
   assign misalign_err = r_misalign;
   assign mem_addr     = r_addr;
   assign mem_wr_data  = r_wr_data;
   assign mem_wr_be    = r_be;
   assign dbg_state    = r_state;

endmodule
